chacha_stream_xor: RTL and testbench

CHACHA_STREAM_XOR -- requirements
Module: chacha_stream_xor

---
 rtl/chacha_stream_xor.sv | 162 ++++++++++++++++
 tb/tb_chacha_stream_xor.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: buffers a plaintext byte stream into blocks, requests one
// keystream block per buffered block and emits the XOR of the two as ciphertext.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   in_data/in_valid/in_ready/in_last plaintext bytes; in_last closes a block
//   out_data/out_valid/out_ready/out_last ciphertext bytes; out_last ends a block
//   ctr_load/ctr_value                block counter load, honoured only when idle and empty
//   ks_start/ks_ctr/ks_ready          keystream request towards the core
//   ks_valid/ks_data                  keystream result, byte i at ks_data[511-8i -: 8]
//   ctr_out, busy                     current block counter, not-in-FILL flag
module chacha_stream_xor #(
    parameter int BLOCK_BYTES  = 64,
    parameter int IDLE_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_last,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    input  logic         ctr_load,
    input  logic [63:0]  ctr_value,
    output logic         ks_start,
    output logic [63:0]  ks_ctr,
    input  logic         ks_ready,
    input  logic         ks_valid,
    input  logic [511:0] ks_data,
    output logic [63:0]  ctr_out,
    output logic         busy
);

    typedef enum logic [1:0] {FILL, REQ, WAIT, SEND} state_e;

    localparam logic [6:0]  BB = 7'(BLOCK_BYTES);
    localparam logic [31:0] TO = 32'(IDLE_TIMEOUT);

    state_e      state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] idle_q, idle_d;
    logic [63:0] ctr_q, ctr_d;
    logic [7:0]  dout_q, dout_d;
    logic        vld_q, vld_d;
    logic        last_q, last_d;

    logic [7:0]  buf_q [64];
    logic [7:0]  ks_q [64];

    logic        accept;
    logic        timeout;
    logic        flush;
    logic [5:0]  sel_idx;
    logic        sel_last;
    logic [7:0]  xor_byte;

    assign in_ready = (state_q == FILL) && (count_q < BB);
    assign accept   = in_valid && in_ready;

    // Timeout fires on the cycle the idle count would reach the limit.
    assign timeout  = (TO != 32'd0) && (count_q != 7'd0) && !accept
                      && ((idle_q + 32'd1) == TO);
    assign flush    = (accept && (in_last || (count_q + 7'd1) == BB))
                      || timeout;

    // Byte to present: current index on SEND entry, next one after a handshake.
    assign sel_idx  = vld_q ? idx_q + 6'd1 : idx_q;
    assign sel_last = ({1'b0, sel_idx} + 7'd1) == count_q;
    assign xor_byte = buf_q[sel_idx] ^ ks_q[sel_idx];

    assign ks_start  = (state_q == REQ) && ks_ready;
    assign ks_ctr    = ctr_q;
    assign ctr_out   = ctr_q;
    assign busy      = (state_q != FILL);
    assign out_data  = dout_q;
    assign out_valid = vld_q;
    assign out_last  = last_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        idle_d  = idle_q;
        ctr_d   = ctr_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        last_d  = last_q;
        unique case (state_q)
            FILL: begin
                if (ctr_load && count_q == 7'd0) ctr_d = ctr_value;
                if (accept) count_d = count_q + 7'd1;
                if (accept || count_q == 7'd0) idle_d = '0;
                else idle_d = idle_q + 32'd1;
                if (flush) begin
                    state_d = REQ;
                    idle_d  = '0;
                end
            end
            REQ: begin
                if (ks_ready) state_d = WAIT;
            end
            WAIT: begin
                idx_d = '0;
                if (ks_valid) state_d = SEND;
            end
            SEND: begin
                if (!vld_q) begin
                    vld_d  = 1'b1;
                    dout_d = xor_byte;
                    last_d = sel_last;
                end else if (out_ready) begin
                    if (last_q) begin
                        vld_d   = 1'b0;
                        last_d  = 1'b0;
                        ctr_d   = ctr_q + 64'd1;
                        count_d = '0;
                        state_d = FILL;
                    end else begin
                        idx_d  = sel_idx;
                        dout_d = xor_byte;
                        last_d = sel_last;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            count_q <= '0;
            idx_q   <= '0;
            idle_q  <= '0;
            ctr_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            idle_q  <= idle_d;
            ctr_q   <= ctr_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    // Data storage needs no reset; contents are only read after being written.
    always_ff @(posedge clk) begin
        if (accept) buf_q[count_q[5:0]] <= in_data;
        if (state_q == WAIT && ks_valid) begin
            for (int i = 0; i < 64; i++) ks_q[i] <= ks_data[511-8*i -: 8];
        end
    end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Bench for chacha_stream_xor: table of blocks checked through a scoreboard,
// plus hand sequences for ctr_load in SEND and reset while waiting on the core.
module tb_chacha_stream_xor;

    localparam int BB = 64;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         ctr_load;
    logic [63:0]  ctr_value;
    logic         ks_start;
    logic [63:0]  ks_ctr;
    logic         ks_ready;
    logic         ks_valid;
    logic [511:0] ks_data;
    logic [63:0]  ctr_out;
    logic         busy;

    chacha_stream_xor #(.BLOCK_BYTES(BB), .IDLE_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last),
        .ctr_load(ctr_load), .ctr_value(ctr_value),
        .ks_start(ks_start), .ks_ctr(ks_ctr), .ks_ready(ks_ready),
        .ks_valid(ks_valid), .ks_data(ks_data),
        .ctr_out(ctr_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  d0;
        logic [7:0]  dstep;
        logic [7:0]  kb;
        logic [7:0]  kstep;
        bit          use_last;
        bit          load;
        logic [63:0] load_val;
        bit          rnd;
        logic [63:0] exp_ctr;
        logic [7:0]  exp_first;
        logic [7:0]  exp_final;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        bit         last;
    } exp_t;

    vec_t        vecs[9];
    exp_t        sb[$];
    logic [7:0]  out_log[$];
    logic [63:0] seen_ctr[$];
    int          n_start;
    int          tests = 0;
    int          fails = 0;
    logic [7:0]  ks_base;
    logic [7:0]  ks_step;
    bit          core_en = 1'b1;
    bit          pulse_req = 1'b0;
    bit          rand_ready = 1'b0;
    bit          fixed_ready = 1'b1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Keystream core model: answers each ks_start two cycles later.
    initial begin
        ks_valid = 1'b0;
        ks_data  = '0;
        ks_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (pulse_req) begin
                pulse_req = 1'b0;
                ks_valid  = 1'b1;
                @(negedge clk);
                ks_valid  = 1'b0;
            end else if (core_en && ks_start) begin
                seen_ctr.push_back(ks_ctr);
                n_start++;
                @(negedge clk);
                @(negedge clk);
                for (int i = 0; i < 64; i++)
                    ks_data[511-8*i -: 8] = 8'(ks_base + ks_step * 8'(i));
                ks_valid = 1'b1;
                @(negedge clk);
                ks_valid = 1'b0;
            end
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : fixed_ready;
        end
    end

    // Output monitor: scoreboard compare, hold-while-stalled, in_ready when busy.
    initial begin
        logic       pv;
        logic [7:0] pd;
        logic       pl;
        exp_t       e;
        pv = 1'b0;
        pd = '0;
        pl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pv) begin
                    check("hold_valid", 64'(out_valid), 64'd1);
                    check("hold_data", 64'(out_data), 64'(pd));
                    check("hold_last", 64'(out_last), 64'(pl));
                end
                if (busy) check("in_ready_busy", 64'(in_ready), 64'd0);
                if (out_valid && out_ready) begin
                    out_log.push_back(out_data);
                    if (sb.size() == 0) begin
                        check("unexpected_out", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", 64'(out_data), 64'(e.d));
                        check("out_last", 64'(out_last), 64'(e.last));
                    end
                end
                pv = out_valid && !out_ready;
                pd = out_data;
                pl = out_last;
            end else begin
                pv = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last,
                             input bit load, input logic [63:0] lv);
        in_data   = d;
        in_valid  = 1'b1;
        in_last   = last;
        ctr_load  = load;
        ctr_value = lv;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_last  = 1'b0;
                ctr_load = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("in_ready_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        ctr_load = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 3000 && sb.size() != 0; k++) @(posedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_block(input vec_t v);
        logic [7:0] d;
        logic [7:0] jj;
        exp_t       e;
        int         cnt;
        ks_base    = v.kb;
        ks_step    = v.kstep;
        rand_ready = v.rnd;
        out_log.delete();
        seen_ctr.delete();
        n_start = 0;
        for (int j = 0; j < v.n; j++) begin
            jj     = 8'(j);
            d      = 8'(v.d0 + v.dstep * jj);
            e.d    = d ^ 8'(v.kb + v.kstep * jj);
            e.last = (j == v.n - 1);
            sb.push_back(e);
            send_byte(d, v.use_last && (j == v.n - 1), v.load && (j == 0),
                      v.load_val);
        end
        if (!v.use_last && v.n < BB) begin
            cnt = 0;
            @(negedge clk);
            while (!ks_start && cnt < 50) begin
                cnt++;
                @(negedge clk);
            end
            check("timeout_latency", 64'(cnt), 64'(TO));
        end
        wait_drain();
        rand_ready = 1'b0;
        check("ks_start_count", 64'(n_start), 64'd1);
        if (seen_ctr.size() > 0) check("ks_ctr", seen_ctr[0], v.exp_ctr);
        check("out_count", 64'(out_log.size()), 64'(v.n));
        if (out_log.size() > 0) begin
            check("first_out", 64'(out_log[0]), 64'(v.exp_first));
            check("final_out", 64'(out_log[$]), 64'(v.exp_final));
        end
        check("ctr_out_after", ctr_out, v.exp_ctr + 64'd1);
    endtask

    initial begin
        exp_t e;
        int   k;
        vecs[0] = '{64, 8'h00, 8'h01, 8'hA5, 8'h00, 1'b0, 1'b0, 64'h0,
                    1'b0, 64'h0, 8'hA5, 8'h9A};
        vecs[1] = '{3, 8'h11, 8'h11, 8'hFF, 8'h00, 1'b1, 1'b0, 64'h0,
                    1'b0, 64'h1, 8'hEE, 8'hCC};
        vecs[2] = '{5, 8'h80, 8'h03, 8'h0F, 8'h10, 1'b1, 1'b0, 64'h0,
                    1'b0, 64'h2, 8'h8F, 8'hC3};
        vecs[3] = '{64, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b1, 1'b0, 64'h0,
                    1'b0, 64'h3, 8'hFF, 8'hFF};
        vecs[4] = '{1, 8'h5A, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b0, 64'h0,
                    1'b0, 64'h4, 8'h66, 8'h66};
        vecs[5] = '{20, 8'h01, 8'h07, 8'h5A, 8'h03, 1'b1, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                    64'hFFFF_FFFF_FFFF_FFFF, 8'h5B, 8'h15};
        vecs[6] = '{64, 8'h40, 8'h05, 8'hC3, 8'h07, 1'b0, 1'b0, 64'h0,
                    1'b1, 64'h0, 8'h83, 8'h07};
        vecs[7] = '{2, 8'h70, 8'h01, 8'h0F, 8'h00, 1'b1, 1'b0, 64'h0,
                    1'b0, 64'h2, 8'h7F, 8'h7E};
        vecs[8] = '{4, 8'h10, 8'h10, 8'hAA, 8'h01, 1'b1, 1'b0, 64'h0,
                    1'b0, 64'h0, 8'hBA, 8'hED};

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        ctr_load  = 1'b0;
        ctr_value = '0;
        ks_base   = '0;
        ks_step   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_ks_start", 64'(ks_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ctr_out", ctr_out, 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) run_block(vecs[i]);

        // ctr_load while stalled in SEND must be ignored.
        fixed_ready = 1'b0;
        ks_base = 8'h21;
        ks_step = 8'h00;
        n_start = 0;
        seen_ctr.delete();
        for (int j = 1; j <= 3; j++) begin
            e.d    = 8'(j) ^ 8'h21;
            e.last = (j == 3);
            sb.push_back(e);
            send_byte(8'(j), j == 3, 1'b0, 64'h0);
        end
        k = 0;
        while (!out_valid && k < 100) begin
            k++;
            @(negedge clk);
        end
        check("send_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        ctr_load  = 1'b1;
        ctr_value = 64'h10;
        repeat (3) @(posedge clk);
        #1;
        ctr_load    = 1'b0;
        fixed_ready = 1'b1;
        wait_drain();
        if (seen_ctr.size() > 0) check("load_send_ks_ctr", seen_ctr[0], 64'd1);
        check("load_send_ctr_out", ctr_out, 64'd2);
        run_block(vecs[7]);

        // Reset while waiting on the core, then a stale ks_valid.
        core_en = 1'b0;
        send_byte(8'h44, 1'b0, 1'b0, 64'h0);
        send_byte(8'h55, 1'b1, 1'b0, 64'h0);
        k = 0;
        @(negedge clk);
        while (!ks_start && k < 50) begin
            k++;
            @(negedge clk);
        end
        check("wait_ks_start", 64'(ks_start), 64'd1);
        @(posedge clk);
        #1;
        check("wait_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse_req = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("stale_out_valid", 64'(out_valid), 64'd0);
        check("stale_busy", 64'(busy), 64'd0);
        check("stale_in_ready", 64'(in_ready), 64'd1);
        check("stale_ctr_out", ctr_out, 64'd0);
        core_en = 1'b1;
        @(posedge clk);
        #1;
        run_block(vecs[8]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
